// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment patterns (bit6=a .. bit0=g), special codes
// and the scan-decoder state encoding. The BCD-to-segment encoder uses the same constants.
package seg7_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [1:0] state_t;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_DASH  = 7'b0000001;
    localparam seg_t SEG_BLANK = 7'b0000000;

    localparam logic [3:0] CODE_DASH  = 4'hF;
    localparam logic [3:0] CODE_BLANK = 4'hE;

    localparam state_t IDLE   = 2'd0;
    localparam state_t SETTLE = 2'd1;
    localparam state_t HELD   = 2'd2;

    // Position of the set bit in a one-hot vector (0 when none is set).
    function automatic logic [2:0] onehot_index(input logic [7:0] sel);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the segment encoder: 7-bit pattern to 4-bit code,
// with a flag that tells whether the pattern is one the encoder can produce.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       known
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        code  = 4'h0;
        known = 1'b1;
        case (seg)
            SEG_0:     code = 4'h0;
            SEG_1:     code = 4'h1;
            SEG_2:     code = 4'h2;
            SEG_3:     code = 4'h3;
            SEG_4:     code = 4'h4;
            SEG_5:     code = 4'h5;
            SEG_6:     code = 4'h6;
            SEG_7:     code = 4'h7;
            SEG_8:     code = 4'h8;
            SEG_9:     code = 4'h9;
            SEG_DASH:  code = CODE_DASH;
            SEG_BLANK: code = CODE_BLANK;
            default:   known = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Read-back decoder for the multiplexed display bus: registers the bus, waits for
// STABLE_CYCLES identical samples on a one-hot select, then commits the decoded digit.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg7_in,
    input  logic                    dp_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    clr_err,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   valid_out,
    output logic                    upd,
    output logic                    err_out,
    output logic [2:0]              err_idx
);

    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    logic [6:0]            s_seg, p_seg;
    logic                  s_dp, p_dp;
    logic [NUM_DIGITS-1:0] s_sel, p_sel;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       commit;

    logic       same, sel_onehot, sel_multi;
    logic [2:0] sel_idx;
    logic [3:0] dec_code;
    logic       dec_known;

    seg7_pattern_decode u_decode (
        .seg   (s_seg),
        .code  (dec_code),
        .known (dec_known)
    );

    assign same       = ({s_seg, s_dp, s_sel} == {p_seg, p_dp, p_sel});
    assign sel_multi  = ((s_sel & (s_sel - 1'b1)) != '0);
    assign sel_onehot = (s_sel != '0) && !sel_multi;
    assign sel_idx    = onehot_index(8'(s_sel));

    // Stability filter: the count is the number of identical samples seen on a valid select.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        if (!sel_onehot) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (state == IDLE || !same) begin
            state_nxt = SETTLE;
            cnt_nxt   = 8'd1;
        end else if (state == SETTLE) begin
            cnt_nxt = cnt + 8'd1;
            if (cnt_nxt == STABLE_CNT) begin
                state_nxt = HELD;
                commit    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            s_seg <= '0;
            s_dp  <= 1'b0;
            s_sel <= '0;
            p_seg <= '0;
            p_dp  <= 1'b0;
            p_sel <= '0;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            s_seg <= seg7_in;
            s_dp  <= dp_in;
            s_sel <= dig_sel;
            p_seg <= s_seg;
            p_dp  <= s_dp;
            p_sel <= s_sel;
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: the digit store is a handful of flops, not a RAM, so it is reset like any other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_out <= '0;
            dp_out     <= '0;
            valid_out  <= '0;
            upd        <= 1'b0;
        end else begin
            upd <= commit && dec_known;
            if (commit && dec_known) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (s_sel[i]) begin
                        digits_out[4*i +: 4] <= dec_code;
                        dp_out[i]            <= s_dp;
                        valid_out[i]         <= 1'b1;
                    end
                end
            end
        end
    end

    // A new error in the same cycle as clr_err wins; only the first unknown pattern records its index.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_out <= 1'b0;
            err_idx <= '0;
        end else if (commit && !dec_known) begin
            err_out <= 1'b1;
            if (!err_out || clr_err) err_idx <= sel_idx;
        end else if (sel_multi && (s_sel != p_sel)) begin
            err_out <= 1'b1;
            if (clr_err) err_idx <= '0;
        end else if (clr_err) begin
            err_out <= 1'b0;
            err_idx <= '0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed self-checking bench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=8).
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg7_in;
    logic        dp_in;
    logic [3:0]  dig_sel;
    logic        clr_err;
    logic [15:0] digits_out;
    logic [3:0]  dp_out;
    logic [3:0]  valid_out;
    logic        upd;
    logic        err_out;
    logic [2:0]  err_idx;

    int tests  = 0;
    int failed = 0;
    int pulses = 0;

    seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg7_in    (seg7_in),
        .dp_in      (dp_in),
        .dig_sel    (dig_sel),
        .clr_err    (clr_err),
        .digits_out (digits_out),
        .dp_out     (dp_out),
        .valid_out  (valid_out),
        .upd        (upd),
        .err_out    (err_out),
        .err_idx    (err_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n clocks; inputs change and outputs are observed 1 time unit after each rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (upd === 1'b1) pulses++;
        end
    endtask

    task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input logic dp);
        dig_sel = sel;
        seg7_in = seg;
        dp_in   = dp;
    endtask

    logic [6:0] scan_pat [4];

    initial begin
        scan_pat[0] = 7'b0110000;  // 1
        scan_pat[1] = 7'b1101101;  // 2
        scan_pat[2] = 7'b1111001;  // 3
        scan_pat[3] = 7'b0110011;  // 4

        rst = 1'b1; clr_err = 1'b0;
        drive(4'b0000, 7'b0000000, 1'b0);
        step(3);
        check("reset_digits", digits_out, 16'h0000);
        check("reset_valid", valid_out, 4'b0000);
        check("reset_err", {err_out, err_idx}, 4'h0);
        rst = 1'b0;

        // Single digit 5 on position 0: upd exactly in cycle 9
        drive(4'b0001, 7'b1011011, 1'b0);
        pulses = 0;
        step(8);
        check("first_no_early_upd", pulses, 0);
        step(1);
        check("first_upd", upd, 1'b1);
        check("first_digit", digits_out[3:0], 4'h5);
        check("first_valid", valid_out, 4'b0001);
        step(1);
        check("upd_one_cycle", upd, 1'b0);

        // Scan 1,2,3,4 with dp on digit 2
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            drive(4'b0001 << i, scan_pat[i], (i == 2));
            step(12);
        end
        check("scan_pulses", pulses, 4);
        check("scan_digits", digits_out, 16'h4321);
        check("scan_dp", dp_out, 4'b0100);
        check("scan_valid", valid_out, 4'b1111);

        // 7-cycle glitch dwells on digit 1 never commit
        pulses = 0;
        drive(4'b0010, 7'b1111111, 1'b0); step(7);
        drive(4'b0010, 7'b1111011, 1'b0); step(7);
        drive(4'b0010, 7'b1111111, 1'b0); step(7);
        check("glitch_no_upd", pulses, 0);
        check("glitch_digits", digits_out, 16'h4321);

        // Unknown pattern on digit 3
        pulses = 0;
        drive(4'b1000, 7'b1010101, 1'b0);
        step(10);
        check("unk_err", err_out, 1'b1);
        check("unk_idx", err_idx, 3'd3);
        check("unk_no_upd", pulses, 0);
        check("unk_digits", digits_out, 16'h4321);

        // clr_err coinciding with a new unknown commit on digit 0: new error wins
        drive(4'b0001, 7'b1010101, 1'b0);
        step(8);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        check("clr_vs_new_err", err_out, 1'b1);
        check("clr_vs_new_idx", err_idx, 3'd0);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        check("clr_err_alone", {err_out, err_idx}, 4'h0);

        // Multi-hot select: error without commit
        pulses = 0;
        drive(4'b0011, 7'b1111111, 1'b0);
        step(3);
        check("multi_err", err_out, 1'b1);
        check("multi_idx_kept", err_idx, 3'd0);
        check("multi_no_upd", pulses, 0);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;

        // Blanking select for 20 cycles
        drive(4'b0000, 7'b0000000, 1'b0);
        pulses = 0;
        step(20);
        check("blank_no_err", err_out, 1'b0);
        check("blank_no_upd", pulses, 0);
        check("blank_digits", digits_out, 16'h4321);

        // Reset in cycle 5 of a dwell, inputs held
        drive(4'b0100, 7'b1110000, 1'b1);
        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("midreset_digits", digits_out, 16'h0000);
        check("midreset_valid", valid_out, 4'b0000);
        check("midreset_dp", dp_out, 4'b0000);
        pulses = 0;
        step(8);
        check("midreset_no_early", pulses, 0);
        step(1);
        check("midreset_upd", upd, 1'b1);
        check("midreset_commit", digits_out, 16'h0700);
        check("midreset_dp_commit", dp_out, 4'b0100);

        // Dash and blank codes
        drive(4'b0010, 7'b0000001, 1'b0); step(10);
        drive(4'b0001, 7'b0000000, 1'b0); step(10);
        check("dash_blank", digits_out, 16'h07FE);
        check("dash_blank_valid", valid_out, 4'b0111);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Read-back decoder for the multiplexed 7-segment display bus: it samples the segment lines, decimal point and digit selects, and converts each stable displayed pattern back to a 4-bit digit code per digit position. It is the inverse of the BCD-to-segment encoder. It sits next to the display driver so the self-check logic and the bench can confirm which value is actually shown. A per-sample stability filter rejects scan-transition glitches.

Parameters:
NUM_DIGITS, 4, number of multiplexed digit positions (1..8)
STABLE_CYCLES, 8, consecutive identical samples required before a digit is committed (2..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
seg7_in  in  7  segment lines, active-high, bit6=a … bit0=g
dp_in  in  1  decimal point, active-high
dig_sel  in  NUM_DIGITS  digit enables, active-high, one-hot or all-zero (blanking)
clr_err  in  1  clears err_out and err_idx
digits_out  out  4*NUM_DIGITS  decoded code per digit; digit i at [4i+3:4i]
dp_out  out  NUM_DIGITS  committed decimal point per digit
valid_out  out  NUM_DIGITS  digit i committed at least once since reset
upd  out  1  one-cycle pulse on every commit
err_out  out  1  sticky: unknown pattern or multi-hot dig_sel seen
err_idx  out  3  digit index of the first unknown pattern since the last clear

Behaviour:
- Reset (rst=1 at posedge): digits_out=0, dp_out=0, valid_out=0, upd=0, err_out=0, err_idx=0, stable counter=0, input regs=0, state=IDLE.
- Stage 0: seg7_in, dp_in and dig_sel are registered every cycle (sample S). Every decision uses S and the previous sample P.
- Decode table (7-bit to 4-bit): 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9, 0000001→F (dash), 0000000→E (blank). Any other pattern is unknown.
- FSM states: IDLE, SETTLE, HELD.
  - IDLE: entered when S.dig_sel is zero or multi-hot. Counter=0. No commit.
  - IDLE→SETTLE: when S.dig_sel is one-hot. Counter=1.
  - SETTLE: if S==P, counter+1. If S!=P, counter=1 and state stays SETTLE (or goes to IDLE if the select is invalid).
  - SETTLE→HELD: when counter reaches STABLE_CYCLES. On that edge, commit the digit.
  - HELD: no further commits while S==P. Any change returns to SETTLE with counter=1, or to IDLE.
- Commit for index i (from the one-hot select):
  - Known pattern: digits_out[i]=code, dp_out[i]=S.dp, valid_out[i]=1, upd=1 for exactly one cycle.
  - Unknown pattern: digits_out, dp_out and valid_out are unchanged; upd=0; err_out=1. err_idx=i only if err_out was 0 (first error is held).
- Multi-hot dig_sel sets err_out on the first such sample; err_idx is unchanged. All-zero dig_sel is legal blanking and never an error.
- Latency: a value applied and held from cycle k gives upd high in cycle k+STABLE_CYCLES+1 (1 cycle input register + STABLE_CYCLES stability count). A dwell shorter than STABLE_CYCLES samples never commits.
- Counter saturates at STABLE_CYCLES; it never wraps.
- clr_err clears err_out and err_idx. If clr_err and a new error occur in the same cycle, the new error wins: err_out=1 and err_idx=new index.
- Reset mid-dwell discards partial counts. The first commit after reset needs a full STABLE_CYCLES dwell.
- Re-displaying the same digit after a select change commits again, so upd pulses again.

Decomposition:
- Shared package seg7_pkg: SEG_* 7-bit pattern constants, CODE_DASH=4'hF, CODE_BLANK=4'hE, and a state enum {IDLE, SETTLE, HELD}. The existing encoder should take its patterns from the same constants.
- One sub-module: seg7_pattern_decode (combinational; 7-bit in, 4-bit code plus known flag out). Keep the stability FSM and the storage in the top level.

Test Plan:
- Reset, then hold dig_sel=0001 and seg7=1011011 (5) for 8 cycles → upd pulses once in cycle 9; digits_out[3:0]=5; valid_out=0001.
- Scan 4 digits with patterns for 1,2,3,4 and a 12-cycle dwell each, dp on digit 2 → digits_out=16'h4321, dp_out=0100, 4 upd pulses.
- Apply glitch dwells of 7 cycles on digit 1 → no upd, and digit 1 stays unchanged.
- Hold pattern 1010101 on digit 3 for 8 cycles → err_out=1, err_idx=3, digits unchanged. clr_err together with a new unknown pattern on digit 0 → err_out=1, err_idx=0.
- Set dig_sel=0011 → err_out=1 with no commit. dig_sel=0000 for 20 cycles → no error and no upd.
- Assert rst at cycle 5 of a dwell, release, and keep the same inputs → outputs 0, and the commit comes STABLE_CYCLES+1 cycles after release.
